// File: rtl/hazard_stall_if.sv
// Pipeline-side bundle for the hazard stall unit: ID/EX hazard inputs and the
// write-enable, bubble, flush and mul/div status controls it drives back.
interface hazard_stall_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       id_ex_rd;
    logic             id_ex_memread;
    logic             ex_md_start;
    logic             ex_branch_taken;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             id_ex_bubble;
    logic             ex_mem_bubble;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             md_busy;
    logic             md_done;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd,
               id_ex_memread, ex_md_start, ex_branch_taken,
        input  pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble,
               if_id_flush, id_ex_flush, md_busy, md_done, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd,
               id_ex_memread, ex_md_start, ex_branch_taken,
        output pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble,
               if_id_flush, id_ex_flush, md_busy, md_done, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush control for hazards forwarding cannot cover: load-use bubbles,
// counted mul/div freezes of EX, and taken-branch flushes.
module hazard_stall_unit #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_stall_if.slave bus
);
    typedef enum logic {RUN, MD_BUSY} state_t;

    localparam logic [3:0] CNT_INIT = (MD_LATENCY > 1) ? 4'(MD_LATENCY - 2) : 4'd0;

    state_t           state, state_next;
    logic [3:0]       cnt, cnt_next;
    logic [CNT_W-1:0] stall_cnt;
    logic             load_use;
    logic             pc_write_c;

    assign load_use = bus.id_ex_memread && (bus.id_ex_rd != 5'd0) &&
                      ((bus.id_uses_rs1 && (bus.id_rs1 == bus.id_ex_rd)) ||
                       (bus.id_uses_rs2 && (bus.id_rs2 == bus.id_ex_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (!pc_write_c)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        pc_write_c        = 1'b1;
        bus.if_id_write   = 1'b1;
        bus.id_ex_write   = 1'b1;
        bus.id_ex_bubble  = 1'b0;
        bus.ex_mem_bubble = 1'b0;
        bus.if_id_flush   = 1'b0;
        bus.id_ex_flush   = 1'b0;
        bus.md_busy       = 1'b0;
        bus.md_done       = 1'b0;

        if (!rst_n) begin
            // Outputs are held quiet for the whole reset window, not just after an edge.
            pc_write_c      = 1'b0;
            bus.if_id_write = 1'b0;
            bus.id_ex_write = 1'b0;
            state_next      = RUN;
            cnt_next        = '0;
        end else if ((state == MD_BUSY) || bus.ex_md_start) begin
            pc_write_c        = 1'b0;
            bus.if_id_write   = 1'b0;
            bus.id_ex_write   = 1'b0;
            bus.md_busy       = 1'b1;
            bus.ex_mem_bubble = 1'b1;
            if (state == MD_BUSY) begin
                if (cnt == 4'd0) begin
                    bus.md_done       = 1'b1;
                    bus.ex_mem_bubble = 1'b0;
                    state_next        = RUN;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end else if (MD_LATENCY == 1) begin
                bus.md_done       = 1'b1;
                bus.ex_mem_bubble = 1'b0;
            end else begin
                state_next = MD_BUSY;
                cnt_next   = CNT_INIT;
            end
        end else if (bus.ex_branch_taken) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write_c       = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_bubble = 1'b1;
        end
    end

    assign bus.pc_write     = pc_write_c;
    assign bus.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Random and directed stimulus with a cycle-level reference model feeding a
// scoreboard queue; a separate monitor pops and compares each cycle.
module tb_hazard_stall_unit;
    localparam int unsigned LAT = 4;

    typedef struct packed {
        logic [8:0]  ctl;
        logic [31:0] stall;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sbq[$];
    int   total;
    int   bad;

    // Reference state: busy cycles already spent on the current op, and the stall total.
    int unsigned md_k;
    logic [31:0] stall_m;

    hazard_stall_if #(.CNT_W(32)) bus ();

    hazard_stall_unit #(.MD_LATENCY(LAT), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic mr, input logic ms, input logic br);
        logic pcw, ifw, idw, bub, emb, ff1, ff2, busy, done;
        int unsigned k;
        exp_t e;
        @(negedge clk);
        rst_n               = rst;
        bus.id_rs1          = rs1;
        bus.id_rs2          = rs2;
        bus.id_uses_rs1     = u1;
        bus.id_uses_rs2     = u2;
        bus.id_ex_rd        = rd;
        bus.id_ex_memread   = mr;
        bus.ex_md_start     = ms;
        bus.ex_branch_taken = br;
        {pcw, ifw, idw, bub, emb, ff1, ff2, busy, done} = 9'b111_000000;
        if (!rst) begin
            {pcw, ifw, idw} = 3'b000;
            md_k    = 0;
            stall_m = 32'd0;
        end else if (md_k > 0 || ms) begin
            k    = md_k + 1;
            {pcw, ifw, idw} = 3'b000;
            busy = 1'b1;
            done = (k == LAT);
            emb  = !done;
            md_k = done ? 0 : k;
        end else if (br) begin
            ff1 = 1'b1;
            ff2 = 1'b1;
        end else if (mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd))) begin
            pcw = 1'b0;
            ifw = 1'b0;
            bub = 1'b1;
        end
        e.ctl   = {pcw, ifw, idw, bub, emb, ff1, ff2, busy, done};
        e.stall = stall_m;
        sbq.push_back(e);
        if (rst && !pcw) stall_m = stall_m + 32'd1;
    endtask

    task automatic idle();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        logic [8:0] got;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e   = sbq.pop_front();
                got = {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.id_ex_bubble,
                       bus.ex_mem_bubble, bus.if_id_flush, bus.id_ex_flush, bus.md_busy,
                       bus.md_done};
                total++;
                if (got !== e.ctl) begin
                    bad++;
                    $display("FAIL ctl t=%0t: got %b want %b", $time, got, e.ctl);
                end
                total++;
                if (bus.stall_cycles !== e.stall) begin
                    bad++;
                    $display("FAIL stall_cycles t=%0t: got %0d want %0d", $time,
                             bus.stall_cycles, e.stall);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        md_k  = 0;
        stall_m = 32'd0;
        rst_n = 1'b0;
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
        bus.id_ex_rd = '0; bus.id_ex_memread = 1'b0; bus.ex_md_start = 1'b0;
        bus.ex_branch_taken = 1'b0;

        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle();
        // load x5 then add x6,x5,x1
        drive(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        idle();
        // load x0, ID reads x0
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        // load x7, ID rs2=7 not used
        drive(1'b1, 5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        // back-to-back load-use
        drive(1'b1, 5'd9, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 5'd4, 5'd12, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        // mul/div, full latency
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (LAT) idle();
        // branch with simultaneous load-use match
        drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
        idle();
        // branch during busy is ignored
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
        repeat (LAT) idle();
        // reset lands in busy cycle 2
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle();
        idle();

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 63) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
        end

        @(negedge clk);
        #4;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline-control counterpart to the EX-stage operand forwarding logic.
- Forwarding resolves data hazards without stalling. This block handles the hazards forwarding cannot resolve:
  - load-use hazards, via a one-cycle bubble;
  - multi-cycle mul/div occupancy in EX, via a counted freeze;
  - taken branches, via an IF/ID and ID/EX flush.
- Sits beside the hazard/forwarding logic. Drives the PC and pipeline-register write enables, bubble controls and flush controls.

Parameters:
- MD_LATENCY, 4: total EX-occupancy cycles of a mul/div op. Legal range 1..15.
- CNT_W, 32: width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- id_ex_rd  in  5  destination of the instruction in EX
- id_ex_memread  in  1  EX instruction is a load
- ex_md_start  in  1  EX instruction is a mul/div (high in its first EX cycle only)
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register write enable
- id_ex_write  out  1  ID/EX register write enable
- id_ex_bubble  out  1  load NOP control into ID/EX
- ex_mem_bubble  out  1  load NOP control into EX/MEM
- if_id_flush  out  1  clear IF/ID
- id_ex_flush  out  1  clear ID/EX
- md_busy  out  1  mul/div occupying EX
- md_done  out  1  one-cycle pulse in the final busy cycle
- stall_cycles  out  CNT_W  count of cycles with pc_write=0

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to RUN; md counter and stall_cycles clear to 0.
  - While rst_n=0, outputs are forced: pc_write=0, if_id_write=0, id_ex_write=0; all bubble, flush, md_busy and md_done outputs = 0.
  - Normal operation starts on the first rising edge after rst_n deasserts.
- Default in RUN with no event: pc_write=1, if_id_write=1, id_ex_write=1; all other control outputs 0.
- FSM states: RUN, MD_BUSY. Outputs are combinational from state and inputs; state and counters are registered.
- Priority within a cycle: mul/div (start or busy) > taken branch > load-use.
- Mul/div start: in RUN with ex_md_start=1, the cycle is busy cycle 1.
  - Outputs: md_busy=1, pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1.
  - If MD_LATENCY=1: md_done=1, ex_mem_bubble=0, stay in RUN.
  - Else: go to MD_BUSY, counter=MD_LATENCY-2.
- MD_BUSY: same freeze outputs as busy cycle 1.
  - counter>0: decrement.
  - counter==0: md_done=1, ex_mem_bubble=0 (result advances to EX/MEM), go to RUN.
  - The op spans exactly MD_LATENCY cycles.
  - ex_branch_taken, ex_md_start and the load-use compare are ignored here.
- Taken branch: in RUN with ex_branch_taken=1 and no md start.
  - Outputs: if_id_flush=1, id_ex_flush=1, pc_write=1.
  - Any simultaneous load-use detection is suppressed; the ID instruction is being discarded.
- Load-use detection: in RUN, no md start, no branch, id_ex_memread=1, id_ex_rd!=0, and either:
  - id_uses_rs1 and id_rs1==id_ex_rd, or
  - id_uses_rs2 and id_rs2==id_ex_rd.
- Load-use response: for one cycle, pc_write=0, if_id_write=0, id_ex_bubble=1. The next cycle the load is in MEM and forwarding covers the hazard.
- Register x0 never causes a stall.
- Back-to-back load-use hazards each stall exactly one cycle.
- stall_cycles increments by 1 on each clock edge where pc_write=0 (rst_n=1). It wraps modulo 2^CNT_W.
- Reset mid-MD_BUSY: aborts immediately to RUN; md_done is not pulsed.

Test Plan:
- Load to x5, then add x6,x5,x1 (uses_rs1=1) -> exactly 1 cycle with pc_write=0 and id_ex_bubble=1; stall_cycles 0->1.
- Load to x0 with ID rs1=0 -> no stall; pc_write stays 1.
- Load to x7 with ID rs2=7 but id_uses_rs2=0 -> no stall.
- ex_md_start pulse, MD_LATENCY=4 -> md_busy high for 4 cycles, md_done only in cycle 4, ex_mem_bubble high in cycles 1-3; stall_cycles +4.
- ex_branch_taken=1 together with a load-use match -> if_id_flush=id_ex_flush=1, pc_write=1, id_ex_bubble=0.
- ex_branch_taken during MD_BUSY -> ignored. Then rst_n low in busy cycle 2 -> outputs forced immediately; after release, RUN defaults with stall_cycles=0.
